// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the stream writer and the display reader.
package fb_pkg;

   localparam int unsigned H_PIX    = 200;
   localparam int unsigned V_PIX    = 150;
   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned FB_DEPTH = H_PIX * V_PIX;

   // One frame-buffer pixel, 2 bits per colour channel.
   typedef struct packed {
      logic [1:0] red;
      logic [1:0] green;
      logic [1:0] blue;
   } rgb222_t;

   function automatic rgb222_t to_rgb222(input logic [5:0] raw);
      return rgb222_t'(raw);
   endfunction

endpackage

// File: rtl/fb_stream_writer_if.sv
// Pixel-stream input and frame-buffer write port of the stream writer.
interface fb_stream_writer_if #(
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
);

   logic              s_valid;
   logic              s_ready;
   logic [5:0]        s_data;
   logic              s_sof;
   logic              hold;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [5:0]        wr_data;
   logic              frame_done;
   logic              sof_err;
   logic              busy;

   // Pixel source / write-port observer side.
   modport master (
      output s_valid, s_data, s_sof, hold,
      input  s_ready, wr_en, wr_addr, wr_data, frame_done, sof_err, busy
   );

   // Stream writer side.
   modport slave (
      input  s_valid, s_data, s_sof, hold,
      output s_ready, wr_en, wr_addr, wr_data, frame_done, sof_err, busy
   );

endinterface

// File: rtl/fb_raster_counter.sv
// Raster position tracker: x/y counters plus a linear address that steps alongside them.
module fb_raster_counter #(
   parameter int unsigned H_PIX  = fb_pkg::H_PIX,
   parameter int unsigned V_PIX  = fb_pkg::V_PIX,
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_inc,
   input  logic              i_clear,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_line_end,
   output logic              o_last_pixel
);

   localparam int unsigned XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
   localparam int unsigned YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;

   logic [XW-1:0]     r_x, w_x_next;
   logic [YW-1:0]     r_y, w_y_next;
   logic [ADDR_W-1:0] r_addr, w_addr_next;
   logic              w_line_end, w_last_pixel;

   assign w_line_end   = (r_x == XW'(H_PIX - 1));
   assign w_last_pixel = w_line_end && (r_y == YW'(V_PIX - 1));

   // Next position: clear+inc restarts one past pixel 0, inc on the last pixel wraps to 0.
   always_comb begin
      w_x_next    = r_x;
      w_y_next    = r_y;
      w_addr_next = r_addr;
      if (i_clear) begin
         w_x_next    = '0;
         w_y_next    = '0;
         w_addr_next = '0;
         if (i_inc) begin
            w_x_next    = XW'(1);
            w_addr_next = ADDR_W'(1);
         end
      end else if (i_inc) begin
         if (w_last_pixel) begin
            w_x_next    = '0;
            w_y_next    = '0;
            w_addr_next = '0;
         end else if (w_line_end) begin
            w_x_next    = '0;
            w_y_next    = r_y + YW'(1);
            w_addr_next = r_addr + ADDR_W'(1);
         end else begin
            w_x_next    = r_x + XW'(1);
            w_addr_next = r_addr + ADDR_W'(1);
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_addr <= '0;
      end else begin
         r_x    <= w_x_next;
         r_y    <= w_y_next;
         r_addr <= w_addr_next;
      end
   end

   assign o_addr       = r_addr;
   assign o_line_end   = w_line_end;
   assign o_last_pixel = w_last_pixel;

endmodule

// File: rtl/fb_stream_writer.sv
// Frame-buffer write side: aligns a raster pixel stream to start-of-frame and writes each pixel.
module fb_stream_writer #(
   parameter int unsigned H_PIX  = fb_pkg::H_PIX,
   parameter int unsigned V_PIX  = fb_pkg::V_PIX,
   parameter int unsigned ADDR_W = fb_pkg::ADDR_W
) (
   input logic               clk,
   input logic               rst_n,
   fb_stream_writer_if.slave bus
);

   import fb_pkg::*;

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   state_e            r_state, w_state_next;
   logic              w_accept;
   logic              w_cnt_inc, w_cnt_clear;
   logic [ADDR_W-1:0] w_cnt_addr;
   logic              w_line_end, w_last_pixel, w_frame_end;
   logic              w_wr_en, w_frame_done, w_sof_err;
   logic [ADDR_W-1:0] w_wr_addr;

   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   rgb222_t           r_wr_data;
   logic              r_frame_done;
   logic              r_sof_err;

   // Ready is held low during reset so nothing is accepted before the FSM is valid.
   assign bus.s_ready = rst_n & ~bus.hold;
   assign w_accept    = bus.s_valid & bus.s_ready;
   assign w_frame_end = w_line_end & w_last_pixel;

   fb_raster_counter #(
      .H_PIX  (H_PIX),
      .V_PIX  (V_PIX),
      .ADDR_W (ADDR_W)
   ) u_raster (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_inc        (w_cnt_inc),
      .i_clear      (w_cnt_clear),
      .o_addr       (w_cnt_addr),
      .o_line_end   (w_line_end),
      .o_last_pixel (w_last_pixel)
   );

   // Next state and write decision for the beat accepted this cycle.
   always_comb begin
      w_state_next = r_state;
      w_cnt_inc    = 1'b0;
      w_cnt_clear  = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_addr    = w_cnt_addr;
      w_frame_done = 1'b0;
      w_sof_err    = 1'b0;
      unique case (r_state)
         StIdle: begin
            // Beats before a start-of-frame are dropped.
            if (w_accept && bus.s_sof) begin
               w_wr_en      = 1'b1;
               w_wr_addr    = '0;
               w_cnt_clear  = 1'b1;
               w_cnt_inc    = 1'b1;
               w_state_next = StWrite;
            end
         end
         StWrite: begin
            if (w_accept) begin
               w_wr_en = 1'b1;
               if (bus.s_sof) begin
                  // Resync: abandon the partial frame and restart at pixel 0.
                  w_sof_err   = 1'b1;
                  w_wr_addr   = '0;
                  w_cnt_clear = 1'b1;
                  w_cnt_inc   = 1'b1;
               end else begin
                  w_cnt_inc = 1'b1;
                  if (w_frame_end) begin
                     w_frame_done = 1'b1;
                     w_state_next = StIdle;
                  end
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Registered write port and status pulses, one cycle after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_sof_err    <= 1'b0;
      end else begin
         r_wr_en      <= w_wr_en;
         r_frame_done <= w_frame_done;
         r_sof_err    <= w_sof_err;
         if (w_wr_en) begin
            r_wr_addr <= w_wr_addr;
            r_wr_data <= to_rgb222(bus.s_data);
         end
      end
   end

   assign bus.wr_en      = r_wr_en;
   assign bus.wr_addr    = r_wr_addr;
   assign bus.wr_data    = r_wr_data;
   assign bus.frame_done = r_frame_done;
   assign bus.sof_err    = r_sof_err;
   assign bus.busy       = (r_state == StWrite);

endmodule

// File: tb/tb_fb_stream_writer.sv
// Directed bench for fb_stream_writer: reset, SOF alignment, full frame with resync, hold, reset.
module tb_fb_stream_writer;

   localparam int unsigned AW = 15;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   fb_stream_writer_if #(.ADDR_W(AW)) bus ();

   fb_stream_writer #(
      .H_PIX  (200),
      .V_PIX  (150),
      .ADDR_W (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor, sampled on the falling edge.
   wr_t wq[$];
   int  fd_cnt  = 0;
   int  fd_addr = -1;
   int  se_cnt  = 0;
   int  se_addr = -1;

   always @(negedge clk) begin
      if (bus.wr_en === 1'b1)
         wq.push_back('{addr: int'(bus.wr_addr), data: int'(bus.wr_data), cyc: cyc});
      if (bus.frame_done === 1'b1) begin
         fd_cnt  <= fd_cnt + 1;
         fd_addr <= int'(bus.wr_addr);
      end
      if (bus.sof_err === 1'b1) begin
         se_cnt  <= se_cnt + 1;
         se_addr <= int'(bus.wr_addr);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Present one beat and let the next rising edge take it.
   task automatic beat(input int data, input logic sof);
      bus.s_valid = 1'b1;
      bus.s_data  = 6'(data);
      bus.s_sof   = sof;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base, fd0, se0, bad_ord, gaps, idx, c, rdy_bad, ea;
      logic h;

      rst_n       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_sof   = 1'b0;
      bus.hold    = 1'b0;

      // Reset state.
      #12;
      chk("rst_wr_en", 32'(bus.wr_en), 0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 0);
      chk("rst_wr_data", 32'(bus.wr_data), 0);
      chk("rst_frame_done", 32'(bus.frame_done), 0);
      chk("rst_sof_err", 32'(bus.sof_err), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_s_ready", 32'(bus.s_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(bus.s_ready), 1);

      // Ten beats without SOF are dropped.
      base = wq.size();
      for (int i = 0; i < 10; i++) beat(i + 1, 1'b0);
      bus.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("nosof_writes", 32'(wq.size() - base), 0);
      chk("nosof_busy", 32'(bus.busy), 0);

      // SOF beat is written at address 0 one cycle later.
      beat(6'h3F, 1'b1);
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      @(negedge clk);
      chk("sof_wr_en", 32'(bus.wr_en), 1);
      chk("sof_wr_addr", 32'(bus.wr_addr), 0);
      chk("sof_wr_data", 32'(bus.wr_data), 32'h3F);
      chk("sof_busy", 32'(bus.busy), 1);
      chk("sof_no_err", 32'(bus.sof_err), 0);
      @(negedge clk);
      chk("sof_single_write", 32'(bus.wr_en), 0);

      // Return to idle through reset.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back: 5000 beats, SOF resync at beat 5000, then a full frame.
      base = wq.size();
      fd0  = fd_cnt;
      se0  = se_cnt;
      for (int i = 0; i < 35000; i++) begin
         idx = (i < 5000) ? i : i - 5000;
         beat(idx % 64, (i == 0) || (i == 5000));
      end
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("frame_write_count", 32'(wq.size() - base), 35000);
      bad_ord = 0;
      gaps    = 0;
      if (wq.size() - base == 35000) begin
         for (int k = 0; k < 35000; k++) begin
            ea = (k < 5000) ? k : k - 5000;
            if (wq[base + k].addr != ea || wq[base + k].data != ea % 64) bad_ord++;
            if (k > 0 && wq[base + k].cyc != wq[base + k - 1].cyc + 1) gaps++;
         end
         chk("wrap_addr_199", 32'(wq[base + 199].addr), 199);
         chk("wrap_addr_200", 32'(wq[base + 200].addr), 200);
         chk("wrap_no_gap", 32'(wq[base + 200].cyc - wq[base + 199].cyc), 1);
         chk("resync_prev_addr", 32'(wq[base + 4999].addr), 4999);
         chk("resync_addr", 32'(wq[base + 5000].addr), 0);
      end
      chk("frame_order_errors", 32'(bad_ord), 0);
      chk("frame_gaps", 32'(gaps), 0);
      chk("sof_err_count", 32'(se_cnt - se0), 1);
      chk("sof_err_addr", 32'(se_addr), 0);
      chk("frame_done_count", 32'(fd_cnt - fd0), 1);
      chk("frame_done_addr", 32'(fd_addr), 29999);
      chk("frame_busy_after", 32'(bus.busy), 0);

      // Hold toggling every 3 cycles, then reset dropped with beat 1233 in flight.
      base    = wq.size();
      idx     = 0;
      c       = 0;
      rdy_bad = 0;
      while (idx < 1234 && c < 10000) begin
         h           = ((c / 3) % 2) == 1;
         bus.hold    = h;
         bus.s_valid = 1'b1;
         bus.s_sof   = (idx == 0);
         bus.s_data  = 6'(idx % 64);
         #1;
         if (bus.s_ready !== !h) rdy_bad++;
         @(posedge clk);
         if (!h) idx++;
         c++;
         #1;
      end
      bus.hold = 1'b0;
      chk("hold_ready_mirror", 32'(rdy_bad), 0);
      chk("hold_write_count", 32'(wq.size() - base), 1233);
      bad_ord = 0;
      for (int k = 0; k < wq.size() - base; k++)
         if (wq[base + k].addr != k || wq[base + k].data != k % 64) bad_ord++;
      chk("hold_order_errors", 32'(bad_ord), 0);
      chk("hold_inflight_en", 32'(bus.wr_en), 1);
      chk("hold_inflight_addr", 32'(bus.wr_addr), 1233);
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", 32'(bus.wr_en), 0);
      chk("midrst_wr_addr", 32'(bus.wr_addr), 0);
      chk("midrst_wr_data", 32'(bus.wr_data), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_s_ready", 32'(bus.s_ready), 0);
      chk("midrst_flags", 32'({bus.frame_done, bus.sof_err}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // After reset, beats without SOF must not write.
      base = wq.size();
      for (int i = 0; i < 20; i++) beat(i, 1'b0);
      bus.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("postrst_writes", 32'(wq.size() - base), 0);
      chk("postrst_busy", 32'(bus.busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
